alu_mdu: RTL

Parametrised iterative multiply/divide unit in the execute stage, next to the single-cycle combinational ALU. It implements the RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a shift-add multiplier and a restoring divider. A valid/ready handshake lets the pipeline stall on it, and `flush` aborts the in-flight operation on a redirect.

---
 rtl/alu_mdu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RV64M multiply/divide unit (shift-add multiplier, restoring divider).
// Define ALU_MDU_WORD_EN to add the `word` port for the 32-bit W variants (WIDTH=64 only).
module alu_mdu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
`ifdef ALU_MDU_WORD_EN
  input  logic             word,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);
  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | one multiply or divide step per cycle
  // DONE  | result held on c until out_ready or flush
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic               accept, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [WIDTH-1:0]   a_ext, b_ext, min_val, a_mag, b_mag, spec_res, dvd_init;
  logic [2*WIDTH-1:0] mcand_init, acc_init;
  logic [CW-1:0]      cnt_init, cnt;
  logic [2:0]         op_q;
  logic               spec_q, qneg_q, rneg_q;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier, rem, dvd, dvsr, r_diff, iter_res, res;
  logic [WIDTH:0]     r_shift;
  logic               q_bit;
`ifdef ALU_MDU_WORD_EN
  logic               word_q;
`endif

  assign accept = (state == IDLE) && in_valid && !flush;

  always_comb begin
    a_sgn    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_ext    = a;
    b_ext    = b;
    min_val  = {1'b1, {(WIDTH-1){1'b0}}};
    cnt_init = CW'(WIDTH-1);
`ifdef ALU_MDU_WORD_EN
    if (word) begin
      a_ext    = {{(WIDTH-32){a_sgn & a[31]}}, a[31:0]};
      b_ext    = {{(WIDTH-32){b_sgn & b[31]}}, b[31:0]};
      min_val  = {{(WIDTH-31){1'b1}}, 31'd0};
      cnt_init = CW'(31);
    end
`endif
    a_neg    = a_sgn & a_ext[WIDTH-1];
    b_neg    = b_sgn & b_ext[WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    dvd_init = a_mag;
`ifdef ALU_MDU_WORD_EN
    // word divides consume only 32 dividend bits, so start them at the top
    if (word) dvd_init = {a_mag[31:0], {(WIDTH-32){1'b0}}};
`endif
    b_zero   = (b_ext == '0);
    ovf      = b_sgn && op[2] && (a_ext == min_val) && (b_ext == '1);
    special  = op[2] && (b_zero || ovf);
    if (b_zero) spec_res = op[1] ? a_ext : '1;
    else        spec_res = op[1] ? '0 : a_ext;
    mcand_init = {{WIDTH{a_neg}}, a_ext};
    // signed b: its top bit weighs -2^(W-1), so pre-subtract a*2^W
    acc_init   = b_neg ? -{a_ext, {WIDTH{1'b0}}} : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    r_shift = {rem, dvd[WIDTH-1]};
    q_bit   = (r_shift >= {1'b0, dvsr});
    r_diff  = r_shift[WIDTH-1:0] - dvsr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      spec_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvsr   <= '0;
`ifdef ALU_MDU_WORD_EN
      word_q <= 1'b0;
`endif
    end else if (accept) begin
      op_q   <= op;
      spec_q <= special;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      cnt    <= cnt_init;
      acc    <= special ? {{WIDTH{1'b0}}, spec_res} : acc_init;
      mcand  <= mcand_init;
      mplier <= b_ext;
      rem    <= '0;
      dvd    <= dvd_init;
      dvsr   <= b_mag;
`ifdef ALU_MDU_WORD_EN
      word_q <= word;
`endif
    end else if (state == BUSY) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (op_q[2]) begin
        rem <= q_bit ? r_diff : r_shift[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], q_bit};
      end else begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  // result is a pure function of the held registers, so it is stable in DONE
  always_comb begin
    iter_res = '0;
    case (op_q)
      3'd0:             iter_res = acc[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: iter_res = acc[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       iter_res = qneg_q ? -dvd : dvd;
      default:          iter_res = rneg_q ? -rem : rem;
    endcase
    res = spec_q ? acc[WIDTH-1:0] : iter_res;
`ifdef ALU_MDU_WORD_EN
    if (word_q) res = {{(WIDTH-32){res[31]}}, res[31:0]};
`endif
    c = res;
  end

endmodule
